// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the E stage. The instruction is held in E until the
// {HI,LO} result is ready, and the result then stays valid while an external stall persists.
module muldiv_unit #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        extStall,
  input  logic        cancelE,
  output logic        busyE,
  output logic        resultValidE,
  output logic [63:0] hiloE,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_dvs;
  logic [63:0] r_rem;
  logic [5:0]  r_cnt;
  logic [63:0] r_hilo;

  logic        w_start;
  logic        w_in_signed;
  logic [31:0] w_in_mag_a;
  logic [31:0] w_in_mag_b;
  logic        w_is_div;
  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [32:0] w_up;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_rem_next;
  logic [31:0] w_quo_fin;
  logic [31:0] w_rmd_fin;
  logic        w_div_zero;
  logic        w_last;

  // Handshake: busyE asks the hazard unit to stall the whole pipe; the instruction may leave E
  // only in a cycle where resultValidE=1 and extStall=0. cancelE overrides both immediately.
  assign w_start     = (r_state == S_IDLE) && startE && !cancelE;
  assign w_in_signed = !opE[0];
  assign w_in_mag_a  = (w_in_signed && srcaE[31]) ? (32'd0 - srcaE) : srcaE;
  assign w_in_mag_b  = (w_in_signed && srcbE[31]) ? (32'd0 - srcbE) : srcbE;

  assign w_is_div = r_op[1];
  assign w_signed = !r_op[0];
  assign w_a_ext  = {{32{w_signed & r_a[31]}}, r_a};
  assign w_b_ext  = {{32{w_signed & r_b[31]}}, r_b};
  assign w_prod   = w_a_ext * w_b_ext;

  // One restoring step: upper 33 bits of the shifted remainder against the divisor magnitude.
  assign w_up       = r_rem[63:31];
  assign w_ge       = (w_up >= {1'b0, r_dvs});
  assign w_sub      = w_up[31:0] - r_dvs;
  assign w_rem_next = w_ge ? {w_sub, r_rem[30:0], 1'b1} : {r_rem[62:0], 1'b0};

  assign w_quo_fin = (w_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_rem_next[31:0])
                                                       : w_rem_next[31:0];
  assign w_rmd_fin = (w_signed && r_a[31]) ? (32'd0 - w_rem_next[63:32]) : w_rem_next[63:32];

  assign w_div_zero = (r_b == 32'd0);
  assign w_last     = w_is_div ? (w_div_zero || (r_cnt == DIV_LAST)) : (r_cnt == MUL_LAST);

  always_comb begin
    busyE        = w_start || ((r_state == S_RUN) && !cancelE);
    resultValidE = (r_state == S_DONE) && !cancelE;
    hiloE        = r_hilo;
    dbg_state    = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_dvs   <= 32'd0;
      r_rem   <= 64'd0;
      r_cnt   <= 6'd0;
      r_hilo  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op    <= opE;
            r_a     <= srcaE;
            r_b     <= srcbE;
            r_dvs   <= w_in_mag_b;
            r_rem   <= {32'd0, w_in_mag_a};
            r_cnt   <= 6'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancelE) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_state <= S_DONE;
              if (!w_is_div)      r_hilo <= w_prod;
              else if (w_div_zero) r_hilo <= {r_a, 32'hFFFF_FFFF};
              else                 r_hilo <= {w_rmd_fin, w_quo_fin};
            end
          end
        end
        S_DONE: begin
          // startE is still high for the same instruction here, so it must not restart.
          if (cancelE || !extStall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of operations with hand-computed results and
// latencies, then sequences for stall-hold, cancel and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        extStall;
  logic        cancelE;
  logic        busyE;
  logic        resultValidE;
  logic [63:0] hiloE;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  muldiv_unit #(.MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .extStall(extStall), .cancelE(cancelE), .busyE(busyE), .resultValidE(resultValidE),
    .hiloE(hiloE), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered just after a clock edge with the unit idle; drives cycle 0 and returns idle again.
  task automatic run_vec(input vec_t v, input string name);
    logic ok = 1'b1;
    startE = 1'b1;
    opE    = v.op;
    srcaE  = v.a;
    srcbE  = v.b;
    for (int c = 0; c < v.lat; c++) begin
      @(negedge clk);
      if (busyE !== 1'b1 || resultValidE !== 1'b0) ok = 1'b0;
      step();
      if (c == 0) begin
        srcaE = $urandom;
        srcbE = $urandom;
      end
    end
    @(negedge clk);
    check({name, " busy"}, {63'd0, ok}, 64'd1);
    check({name, " done"}, {62'd0, busyE, resultValidE}, 64'd1);
    check({name, " hilo"}, hiloE, v.hilo);
    step();
    startE = 1'b0;
    @(negedge clk);
    check({name, " idle"}, {61'd0, dbg_state, resultValidE}, 64'd0);
    step();
  endtask

  initial begin
    logic ok_run;
    logic ok_done;
    logic [63:0] prev;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 4};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 33};
    vecs[4]  = '{2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 2};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
    vecs[6]  = '{2'b00, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 4};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
    vecs[8]  = '{2'b10, 32'd0,         32'd0,         64'h0000_0000_FFFF_FFFF, 2};
    vecs[9]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 4};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 33};
    vecs[11] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4};
    vecs[12] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002, 33};

    rst = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
    extStall = 1'b0; cancelE = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs", {busyE, resultValidE, dbg_state, hiloE[59:0]}, 64'd0);
    check("reset hi", {32'd0, hiloE[63:32]}, 64'd0);
    step();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start and cancel in the same cycle: nothing begins
    startE = 1'b1; cancelE = 1'b1; opE = 2'b00; srcaE = 32'd3; srcbE = 32'd4;
    @(negedge clk);
    check("cancel at start busy", {63'd0, busyE}, 64'd0);
    step();
    startE = 1'b0; cancelE = 1'b0;
    @(negedge clk);
    check("cancel at start idle", {62'd0, dbg_state}, 64'd0);
    step();

    // DIV 100/7 with extStall over cycles 30..40: result held in DONE, no restart
    startE = 1'b1; opE = 2'b10; srcaE = 32'd100; srcbE = 32'd7;
    ok_run = 1'b1; ok_done = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      extStall = (c >= 30 && c <= 40);
      if (c == 1) begin
        srcaE = $urandom;
        srcbE = $urandom;
      end
      @(negedge clk);
      if (c <= 32) begin
        if (busyE !== 1'b1 || resultValidE !== 1'b0) ok_run = 1'b0;
      end else begin
        if (busyE !== 1'b0 || resultValidE !== 1'b1 || hiloE !== 64'h0000_0002_0000_000E)
          ok_done = 1'b0;
      end
      step();
    end
    startE = 1'b0; extStall = 1'b0;
    check("stall run", {63'd0, ok_run}, 64'd1);
    check("stall hold", {63'd0, ok_done}, 64'd1);
    @(negedge clk);
    check("stall exit", {61'd0, dbg_state, resultValidE}, 64'd0);
    step();

    // cancel a DIV at cycle 10, then a MULT from cycle 12
    prev = 64'h0000_0002_0000_000E;
    startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
    for (int c = 0; c < 10; c++) step();
    cancelE = 1'b1;
    @(negedge clk);
    check("cancel busy", {62'd0, busyE, resultValidE}, 64'd0);
    step();
    cancelE = 1'b0; startE = 1'b0;
    @(negedge clk);
    check("cancel idle", {61'd0, dbg_state, resultValidE}, 64'd0);
    check("cancel hilo kept", hiloE, prev);
    step();
    run_vec('{2'b00, 32'd5, 32'd6, 64'd30, 4}, "post cancel mult");

    // reset in the middle of a MULTU, then a MULT
    startE = 1'b1; opE = 2'b01; srcaE = 32'd9; srcbE = 32'd9;
    step();
    step();
    rst = 1'b1; startE = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrun rst", {busyE, resultValidE, dbg_state, 60'd0}, 64'd0);
    check("midrun rst hilo", hiloE, 64'd0);
    step();
    run_vec('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 4}, "post rst mult");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
